// File: rtl/excpt_ctrl_pkg.sv
// Shared constants, FSM state type and CP0 register packing helpers
// for the exception controller.
package excpt_ctrl_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;

   localparam logic RST_ENABLE = 1'b0;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } excpt_state_e;

   function automatic logic [31:0] pack_status(input logic [5:0] im, input logic exl, input logic ie);
      return {16'd0, im, 8'd0, exl, ie};
   endfunction

   function automatic logic [31:0] pack_cause(input logic [5:0] ip, input logic [4:0] exccode);
      return {16'd0, ip, 3'd0, exccode, 2'd0};
   endfunction

endpackage

// File: rtl/excpt_ctrl_if.sv
// Execute-stage / CP0 / fetch-redirect signal bundle of the exception controller.
interface excpt_ctrl_if;
   logic [4:0]  intr;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        syscall;
   logic        eret;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_data;
   logic [4:0]  mfc0_addr;
   logic [31:0] mfc0_data;
   logic        excpt;
   logic [31:0] ejpc;

   modport master (
      output intr, ex_valid, ex_pc, syscall, eret,
      output mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
      input  mfc0_data, excpt, ejpc
   );

   modport slave (
      input  intr, ex_valid, ex_pc, syscall, eret,
      input  mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
      output mfc0_data, excpt, ejpc
   );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare pair with a sticky timer-pending flag that a Compare
// write clears.
module cp0_timer
   import excpt_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_ip
);

   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic        timer_ip_r;

   // Free-running counter, Compare register and pending flag
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         count_r    <= 32'd0;
         compare_r  <= 32'd0;
         timer_ip_r <= 1'b0;
      end else begin
         if (count_we) begin
            count_r <= wdata;
         end else begin
            count_r <= count_r + 32'd1;
         end
         if (compare_we) begin
            compare_r  <= wdata;
            timer_ip_r <= 1'b0;
         end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
            timer_ip_r <= 1'b1;
         end else begin
            timer_ip_r <= timer_ip_r;
         end
      end
   end

   assign count    = count_r;
   assign compare  = compare_r;
   assign timer_ip = timer_ip_r;

endmodule

// File: rtl/excpt_ctrl.sv
// Exception/interrupt controller: CP0 Status/Cause/EPC, event arbitration
// and the zero-latency fetch redirect with a post-redirect flush window.
module excpt_ctrl
   import excpt_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic          clk,
   input logic          rst,
   excpt_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   excpt_state_e     state_r, state_nxt_s;
   logic [CNT_W-1:0] flush_cnt_r, flush_cnt_nxt_s;

   logic        ie_r, exl_r;
   logic [5:0]  im_r;
   logic [4:0]  ip_ext_r;
   logic [4:0]  exccode_r;
   logic [31:0] epc_r;

   logic [5:0]  ip_s;
   logic        int_pend_s;
   logic        take_int_s, take_sys_s, take_eret_s, event_s;
   logic        wr_s;
   logic [31:0] count_s, compare_s;
   logic        timer_ip_s;

   assign ip_s       = {timer_ip_s, ip_ext_r};
   assign int_pend_s = ie_r && !exl_r && (|(ip_s & im_r));
   // A write that coincides with an accepted event is dropped entirely
   assign wr_s       = bus.mtc0_we && !event_s;

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_s && (bus.mtc0_addr == CP0_COUNT)),
      .compare_we (wr_s && (bus.mtc0_addr == CP0_COMPARE)),
      .wdata      (bus.mtc0_data),
      .count      (count_s),
      .compare    (compare_s),
      .timer_ip   (timer_ip_s)
   );

   // FSM state and flush counter register
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state_r     <= ST_RUN;
         flush_cnt_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         flush_cnt_r <= flush_cnt_nxt_s;
      end
   end

   // Event arbitration, next state and redirect outputs
   always_comb begin
      state_nxt_s     = state_r;
      flush_cnt_nxt_s = flush_cnt_r;
      take_int_s      = 1'b0;
      take_sys_s      = 1'b0;
      take_eret_s     = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (bus.ex_valid) begin
               if (int_pend_s) begin
                  take_int_s = 1'b1;
               end else if (bus.syscall) begin
                  take_sys_s = 1'b1;
               end else if (bus.eret) begin
                  take_eret_s = 1'b1;
               end else begin
                  take_int_s = 1'b0;
               end
            end else begin
               take_int_s = 1'b0;
            end
            if (take_int_s || take_sys_s || take_eret_s) begin
               state_nxt_s     = ST_FLUSH;
               flush_cnt_nxt_s = CNT_LOAD;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_r == '0) begin
               state_nxt_s = ST_RUN;
            end else begin
               flush_cnt_nxt_s = flush_cnt_r - CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s     = ST_RUN;
            flush_cnt_nxt_s = '0;
         end
      endcase
      event_s = take_int_s || take_sys_s || take_eret_s;
      bus.excpt = event_s;
      if (take_eret_s) begin
         bus.ejpc = epc_r;
      end else if (event_s) begin
         bus.ejpc = EXC_VECTOR;
      end else begin
         bus.ejpc = 32'd0;
      end
   end

   // Status, Cause and EPC updates from events and the mtc0 port
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         ie_r      <= 1'b0;
         exl_r     <= 1'b0;
         im_r      <= 6'd0;
         ip_ext_r  <= 5'd0;
         exccode_r <= 5'd0;
         epc_r     <= 32'd0;
      end else begin
         ip_ext_r <= bus.intr;
         if (take_int_s || take_sys_s) begin
            epc_r     <= bus.ex_pc;
            exl_r     <= 1'b1;
            exccode_r <= take_int_s ? EXC_INT : EXC_SYS;
         end else if (take_eret_s) begin
            exl_r <= 1'b0;
         end else begin
            if (wr_s && (bus.mtc0_addr == CP0_STATUS)) begin
               ie_r  <= bus.mtc0_data[0];
               exl_r <= bus.mtc0_data[1];
               im_r  <= bus.mtc0_data[15:10];
            end else begin
               im_r <= im_r;
            end
            if (wr_s && (bus.mtc0_addr == CP0_EPC)) begin
               epc_r <= bus.mtc0_data;
            end else begin
               epc_r <= epc_r;
            end
         end
      end
   end

   // Combinational CP0 read port
   always_comb begin
      case (bus.mfc0_addr)
         CP0_COUNT:   bus.mfc0_data = count_s;
         CP0_COMPARE: bus.mfc0_data = compare_s;
         CP0_STATUS:  bus.mfc0_data = pack_status(im_r, exl_r, ie_r);
         CP0_CAUSE:   bus.mfc0_data = pack_cause(ip_s, exccode_r);
         CP0_EPC:     bus.mfc0_data = epc_r;
         default:     bus.mfc0_data = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_excpt_ctrl.sv
// Directed self-checking bench for excpt_ctrl: syscall, eret, masked and
// unmasked interrupts, timer, simultaneous events and reset during flush.
`timescale 1ns/1ps
module tb_excpt_ctrl;
   import excpt_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   excpt_ctrl_if bus();

   excpt_ctrl #(.EXC_VECTOR(32'h0000_0040), .FLUSH_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #50 clk = ~clk;

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus.mfc0_addr = a;
      #1;
      d = bus.mfc0_data;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.mtc0_we   = 1'b1;
      bus.mtc0_addr = a;
      bus.mtc0_data = d;
      @(posedge clk);
      #1;
      bus.mtc0_we = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [4:0]  addrs [5];
      addrs = '{CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC};
      @(negedge clk);
      #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL reset_excpt: got %b expected 0", bus.excpt); end
      checks++; if (bus.ejpc !== 32'd0) begin errors++; $display("FAIL reset_ejpc: got %h expected 0", bus.ejpc); end
      for (int i = 0; i < 5; i++) begin
         rd(addrs[i], d);
         checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", addrs[i], d); end
      end
      rst = 1'b1;
   endtask

   task automatic test_syscall();
      logic [31:0] d;
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_pc = 32'h100; bus.syscall = 1'b1;
      #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL sys_excpt: got %b expected 1", bus.excpt); end
      checks++; if (bus.ejpc !== 32'h40) begin errors++; $display("FAIL sys_ejpc: got %h expected 40", bus.ejpc); end
      @(posedge clk); #1;
      bus.syscall = 1'b0; bus.ex_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL sys_one_cycle: got %b expected 0", bus.excpt); end
      checks++; if (bus.ejpc !== 32'd0) begin errors++; $display("FAIL sys_ejpc_idle: got %h expected 0", bus.ejpc); end
      rd(CP0_EPC, d);
      checks++; if (d !== 32'h100) begin errors++; $display("FAIL sys_epc: got %h expected 100", d); end
      rd(CP0_CAUSE, d);
      checks++; if (d !== 32'h20) begin errors++; $display("FAIL sys_cause: got %h expected 20", d); end
      rd(CP0_STATUS, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL sys_status: got %h expected 2", d); end
      rd(5'd3, d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL sys_unmapped: got %h expected 0", d); end
      @(negedge clk);
   endtask

   task automatic test_eret();
      logic [31:0] d;
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_pc = 32'h180; bus.eret = 1'b1;
      #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL eret_excpt: got %b expected 1", bus.excpt); end
      checks++; if (bus.ejpc !== 32'h100) begin errors++; $display("FAIL eret_ejpc: got %h expected 100", bus.ejpc); end
      @(posedge clk); #1;
      bus.eret = 1'b0; bus.ex_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL eret_one_cycle: got %b expected 0", bus.excpt); end
      rd(CP0_STATUS, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL eret_exl: got %h expected 0", d); end
      @(negedge clk);
   endtask

   task automatic test_interrupt();
      logic [31:0] d;
      wr(CP0_STATUS, 32'h0000_0401);
      @(negedge clk);
      bus.intr = 5'b00001; bus.ex_valid = 1'b1; bus.ex_pc = 32'h200;
      #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL int_latency: got %b expected 0", bus.excpt); end
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL int_exvalid_block: got %b expected 0", bus.excpt); end
      @(negedge clk);
      bus.ex_valid = 1'b1;
      #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL int_excpt: got %b expected 1", bus.excpt); end
      checks++; if (bus.ejpc !== 32'h40) begin errors++; $display("FAIL int_ejpc: got %h expected 40", bus.ejpc); end
      @(posedge clk); #1;
      bus.ex_valid = 1'b0; bus.intr = 5'b00000;
      @(negedge clk); #1;
      rd(CP0_CAUSE, d);
      checks++; if (d[6:2] !== 5'd0) begin errors++; $display("FAIL int_exccode: got %0d expected 0", d[6:2]); end
      rd(CP0_EPC, d);
      checks++; if (d !== 32'h200) begin errors++; $display("FAIL int_epc: got %h expected 200", d); end
      rd(CP0_STATUS, d);
      checks++; if (d !== 32'h403) begin errors++; $display("FAIL int_status: got %h expected 403", d); end
      @(negedge clk);
      wr(CP0_STATUS, 32'h0000_0001);
      @(negedge clk);
      bus.intr = 5'b00001; bus.ex_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL int_masked%0d: got %b expected 0", i, bus.excpt); end
      end
      rd(CP0_CAUSE, d);
      checks++; if (d !== 32'h400) begin errors++; $display("FAIL int_ip_visible: got %h expected 400", d); end
      bus.intr = 5'b00000; bus.ex_valid = 1'b0;
   endtask

   task automatic test_timer();
      logic [31:0] d;
      wr(CP0_COUNT, 32'h0000_1000);
      wr(CP0_COMPARE, 32'd20);
      wr(CP0_STATUS, 32'h0000_8001);
      wr(CP0_COUNT, 32'd0);
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         bus.ex_valid = 1'b1; bus.ex_pc = 32'h240;
         #1;
         if (i == 0 || i == 20) begin
            rd(CP0_COUNT, d);
            checks++; if (d !== i) begin errors++; $display("FAIL tmr_count%0d: got %0d expected %0d", i, d, i); end
         end
         checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL tmr_early%0d: got %b expected 0", i, bus.excpt); end
      end
      @(negedge clk); #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL tmr_excpt: got %b expected 1", bus.excpt); end
      checks++; if (bus.ejpc !== 32'h40) begin errors++; $display("FAIL tmr_ejpc: got %h expected 40", bus.ejpc); end
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      @(negedge clk); #1;
      rd(CP0_CAUSE, d);
      checks++; if (d !== 32'h8000) begin errors++; $display("FAIL tmr_ip_set: got %h expected 8000", d); end
      wr(CP0_COMPARE, 32'h0010_0000);
      @(negedge clk); #1;
      rd(CP0_CAUSE, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL tmr_ip_clear: got %h expected 0", d); end
      wr(CP0_STATUS, 32'h0);
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      wr(CP0_STATUS, 32'h0000_0401);
      @(negedge clk);
      bus.intr = 5'b00001; bus.ex_valid = 1'b0;
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.syscall = 1'b1; bus.ex_pc = 32'h300;
      bus.mtc0_we = 1'b1; bus.mtc0_addr = CP0_EPC; bus.mtc0_data = 32'hDEAD_BEEF;
      #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL sim_excpt: got %b expected 1", bus.excpt); end
      checks++; if (bus.ejpc !== 32'h40) begin errors++; $display("FAIL sim_ejpc: got %h expected 40", bus.ejpc); end
      @(posedge clk); #1;
      bus.mtc0_we = 1'b0; bus.intr = 5'b00000;
      @(negedge clk); #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL sim_flush1: got %b expected 0", bus.excpt); end
      rd(CP0_CAUSE, d);
      checks++; if (d[6:2] !== 5'd0) begin errors++; $display("FAIL sim_exccode: got %0d expected 0", d[6:2]); end
      rd(CP0_EPC, d);
      checks++; if (d !== 32'h300) begin errors++; $display("FAIL sim_epc: got %h expected 300", d); end
      @(negedge clk); #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL sim_flush2: got %b expected 0", bus.excpt); end
      @(posedge clk); #1;
      bus.syscall = 1'b0; bus.ex_valid = 1'b0;
      wr(CP0_STATUS, 32'h0);
   endtask

   task automatic test_reset_flush();
      logic [31:0] d;
      logic [4:0]  addrs [5];
      addrs = '{CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC};
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.syscall = 1'b1; bus.ex_pc = 32'h400;
      #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL rf_first_excpt: got %b expected 1", bus.excpt); end
      @(posedge clk); #1;
      bus.syscall = 1'b0; bus.ex_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus.excpt !== 1'b0) begin errors++; $display("FAIL rf_excpt: got %b expected 0", bus.excpt); end
      for (int i = 0; i < 5; i++) begin
         rd(addrs[i], d);
         checks++; if (d !== 32'd0) begin errors++; $display("FAIL rf_reg%0d: got %h expected 0", addrs[i], d); end
      end
      @(negedge clk); #1;
      rst = 1'b1;
      bus.ex_valid = 1'b1; bus.syscall = 1'b1; bus.ex_pc = 32'h500;
      #1;
      checks++; if (bus.excpt !== 1'b1) begin errors++; $display("FAIL rf_post_excpt: got %b expected 1", bus.excpt); end
      checks++; if (bus.ejpc !== 32'h40) begin errors++; $display("FAIL rf_post_ejpc: got %h expected 40", bus.ejpc); end
      @(posedge clk); #1;
      bus.syscall = 1'b0; bus.ex_valid = 1'b0;
      @(negedge clk); #1;
      rd(CP0_EPC, d);
      checks++; if (d !== 32'h500) begin errors++; $display("FAIL rf_epc: got %h expected 500", d); end
      rd(CP0_CAUSE, d);
      checks++; if (d !== 32'h20) begin errors++; $display("FAIL rf_cause: got %h expected 20", d); end
   endtask

   initial begin
      bus.intr      = 5'd0;
      bus.ex_valid  = 1'b0;
      bus.ex_pc     = 32'd0;
      bus.syscall   = 1'b0;
      bus.eret      = 1'b0;
      bus.mtc0_we   = 1'b0;
      bus.mtc0_addr = 5'd0;
      bus.mtc0_data = 32'd0;
      bus.mfc0_addr = 5'd0;
      test_reset();
      test_syscall();
      test_eret();
      test_interrupt();
      test_timer();
      test_simultaneous();
      test_reset_flush();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
